// File: rtl/sar_search4.sv
`default_nettype none
// ============================================================================
//  Module   : sar_search4
//  Brief    : 4-bit successive-approximation search. Probes candidates against
//             an external combinational comparator, one probe per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module sar_search4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cmp_g,
    input  logic       cmp_e,
    input  logic       cmp_l,
    output logic [3:0] cand,
    output logic       busy,
    output logic       done,
    output logic       found,
    output logic       err,
    output logic [3:0] result,
    output logic [2:0] steps
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_probe = 2'd1;
    localparam logic [1:0] c_done  = 2'd2;

    logic [1:0] r_state;
    logic [3:0] r_cand;
    logic [3:0] r_lo;
    logic [3:0] r_hi;
    logic [3:0] r_result;
    logic [2:0] r_steps;
    logic       r_found;
    logic       r_err;

    logic [1:0] w_state_nxt;
    logic [3:0] w_cand_nxt;
    logic [3:0] w_lo_nxt;
    logic [3:0] w_hi_nxt;
    logic [3:0] w_result_nxt;
    logic [2:0] w_steps_nxt;
    logic       w_found_nxt;
    logic       w_err_nxt;

    logic [1:0] w_flag_cnt;
    logic       w_onehot;
    logic [4:0] w_sum_up;
    logic [4:0] w_sum_dn;

    assign w_flag_cnt = {1'b0, cmp_g} + {1'b0, cmp_e} + {1'b0, cmp_l};
    assign w_onehot   = (w_flag_cnt == 2'd1);

    // Midpoints of the shrunken interval; 5-bit sums avoid overflow at 15+15.
    // The down sum is only used when cand > lo, so cand-1 never underflows.
    assign w_sum_up = {1'b0, r_cand} + 5'd1 + {1'b0, r_hi};
    assign w_sum_dn = {1'b0, r_lo} + {1'b0, r_cand} - 5'd1;

    always_comb begin
        w_state_nxt  = r_state;
        w_cand_nxt   = r_cand;
        w_lo_nxt     = r_lo;
        w_hi_nxt     = r_hi;
        w_result_nxt = r_result;
        w_steps_nxt  = r_steps;
        w_found_nxt  = r_found;
        w_err_nxt    = r_err;
        case (r_state)
            c_idle: begin
                if (start) begin
                    w_state_nxt = c_probe;
                    w_lo_nxt    = 4'd0;
                    w_hi_nxt    = 4'd15;
                    w_cand_nxt  = 4'd7;
                    w_steps_nxt = 3'd0;
                    w_found_nxt = 1'b0;
                    w_err_nxt   = 1'b0;
                end
            end
            c_probe: begin
                w_steps_nxt = r_steps + 3'd1;
                if (!w_onehot) begin
                    w_state_nxt = c_done;
                    w_err_nxt   = 1'b1;
                end else if (cmp_e) begin
                    w_state_nxt  = c_done;
                    w_found_nxt  = 1'b1;
                    w_result_nxt = r_cand;
                end else if (cmp_g) begin
                    // Target claimed above the top of the interval: no match.
                    if (r_cand == r_hi) begin
                        w_state_nxt = c_done;
                    end else begin
                        w_lo_nxt   = r_cand + 4'd1;
                        w_cand_nxt = w_sum_up[4:1];
                    end
                end else begin
                    if (r_cand == r_lo) begin
                        w_state_nxt = c_done;
                    end else begin
                        w_hi_nxt   = r_cand - 4'd1;
                        w_cand_nxt = w_sum_dn[4:1];
                    end
                end
            end
            c_done: begin
                w_state_nxt = c_idle;
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_idle;
            r_cand   <= 4'd0;
            r_lo     <= 4'd0;
            r_hi     <= 4'd15;
            r_result <= 4'd0;
            r_steps  <= 3'd0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cand   <= w_cand_nxt;
            r_lo     <= w_lo_nxt;
            r_hi     <= w_hi_nxt;
            r_result <= w_result_nxt;
            r_steps  <= w_steps_nxt;
            r_found  <= w_found_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign cand   = r_cand;
    assign busy   = (r_state == c_probe);
    assign done   = (r_state == c_done);
    assign found  = r_found;
    assign err    = r_err;
    assign result = r_result;
    assign steps  = r_steps;

endmodule
`default_nettype wire

// File: doc/sar_search4.md
SAR_SEARCH4 -- requirements
Module: sar_search4

Interface
REQ-001 The module SHALL have no parameters; the data width is fixed at 4 bits.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new search; sampled only in IDLE.
REQ-005 cmp_g  input  1  from the external comparator: target > cand.
REQ-006 cmp_e  input  1  from the external comparator: target == cand.
REQ-007 cmp_l  input  1  from the external comparator: target < cand.
REQ-008 cand  output  4  current probe value, registered, driven to the external comparator.
REQ-009 busy  output  1  high while in PROBE.
REQ-010 done  output  1  one-cycle pulse when a search ends.
REQ-011 found  output  1  last search matched; valid from the done pulse until the next start.
REQ-012 err  output  1  last search aborted on illegal comparator flags.
REQ-013 result  output  4  matched value; valid when found=1.
REQ-014 steps  output  3  number of probes used by the last or current search, range 0..5.

Function
REQ-015 The state machine SHALL have states IDLE, PROBE and DONE, with a 4-bit lo bound and a 4-bit hi bound.
REQ-016 The IDLE exit SHALL occur on start=1: next cycle state=PROBE, lo=0, hi=15, cand=7, steps=0, found=0, err=0.
REQ-017 In PROBE, the flags SHALL be evaluated in the same cycle against the registered cand, because the external comparator is combinational; each PROBE cycle SHALL increment steps.
REQ-018 If cmp_e=1 (one-hot flags), the next state SHALL be DONE with result=cand and found=1.
REQ-019 If cmp_g=1 and cand!=hi, the block SHALL set lo=cand+1 and load cand=(cand+1+hi)>>1 (5-bit sum) next cycle.
REQ-020 If cmp_l=1 and cand!=lo, the block SHALL set hi=cand-1 and load cand=(lo+cand-1)>>1 next cycle.
REQ-021 If cmp_g=1 with cand==hi, or cmp_l=1 with cand==lo, the next state SHALL be DONE with found=0 and err=0 (inconsistent comparator, no match); no bound wrap is permitted.
REQ-022 If the flags are not exactly one-hot (none set, or more than one set), the next state SHALL be DONE with found=0 and err=1.
REQ-023 DONE SHALL last exactly one cycle: done=1, busy=0, then IDLE.
REQ-024 Latency SHALL be one probe per cycle, with at most 5 probes; start-to-done SHALL be at most 6 cycles after the start sample.
REQ-025 start SHALL be ignored in PROBE and in DONE; a start held high re-triggers from IDLE on the cycle after DONE.
REQ-026 cand, result, found, err and steps SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-027 rst=1 SHALL force, asynchronously: state=IDLE, cand=0, lo=0, hi=15, result=0, steps=0, busy=0, done=0, found=0, err=0.
REQ-028 A reset asserted mid-search SHALL abort the search without a done pulse; the first start after rst deasserts SHALL begin a clean search.

Verification
REQ-029 Target 7 with an ideal comparator model SHALL give the probe 7, a done pulse 2 cycles after start, found=1, result=7, steps=1.
REQ-030 Target 15 SHALL give the probes 7, 11, 13, 14, 15, then found=1, result=15, steps=5.
REQ-031 Target 0 SHALL give the probes 7, 3, 1, 0, then found=1, result=0, steps=4.
REQ-032 A comparator stuck at cmp_l=1 SHALL give the probes 7, 3, 1, 0, then done with found=0, err=0, steps=4.
REQ-033 cmp_g=1 and cmp_l=1 together on the first probe SHALL give done on the next cycle with err=1, found=0, steps=1.
REQ-034 rst pulsed during probe 3 of target 15 SHALL force all outputs to reset values immediately with no done pulse; start then SHALL give a correct 5-probe search.
